// File: rtl/switch_sequencer_pkg.sv
// Shared definitions for the switch sequencer and its slot/frame enable generators.
// Holds the FSM encoding, width helpers and default timebase constants.
package switch_sequencer_pkg;

    typedef logic [1:0] seq_state_t;

    localparam seq_state_t ST_IDLE  = 2'd0;
    localparam seq_state_t ST_ARMED = 2'd1;
    localparam seq_state_t ST_RUN   = 2'd2;
    localparam seq_state_t ST_DRAIN = 2'd3;

    localparam int DEF_NUM_SW      = 4;
    localparam int DEF_NUM_SLOTS   = 8;
    localparam int DEF_DEAD_CYCLES = 2;
    localparam int DEF_FCNT_W      = 16;

    // Index width for n entries, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int DEF_SLOT_W = idx_width(DEF_NUM_SLOTS);

endpackage

// File: rtl/switch_sequencer_sw_blanker.sv
// Drives the switch outputs, forcing a dead-time gap of zeros whenever the
// loaded pattern differs from what is currently being driven.
module sw_blanker #(
    parameter int NUM_SW      = 4,
    parameter int DEAD_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              load,
    input  logic [NUM_SW-1:0] target,
    output logic [NUM_SW-1:0] sw_out
);

    localparam int CW = (DEAD_CYCLES < 1) ? 1 : $clog2(DEAD_CYCLES + 1);

    logic [NUM_SW-1:0] pend_q;
    logic [CW-1:0]     cnt_q;
    logic              blanking;

    assign blanking = (cnt_q != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_out <= '0;
            pend_q <= '0;
            cnt_q  <= '0;
        end else if (clear) begin
            sw_out <= '0;
            cnt_q  <= '0;
        end else if (load) begin
            // A load while blanking always restarts the gap toward the newest pattern.
            if (!blanking && (target == sw_out)) begin
                sw_out <= sw_out;
            end else if (DEAD_CYCLES == 0) begin
                sw_out <= target;
            end else begin
                sw_out <= '0;
                pend_q <= target;
                cnt_q  <= CW'(DEAD_CYCLES);
            end
        end else if (blanking) begin
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                sw_out <= pend_q;
            end
        end
    end

endmodule

// File: rtl/switch_sequencer.sv
// Frame/slot pattern sequencer with a double-buffered pattern table that
// swaps atomically on frame boundaries, plus timebase misalignment detection.
module switch_sequencer
    import switch_sequencer_pkg::*;
#(
    parameter int NUM_SW      = DEF_NUM_SW,
    parameter int NUM_SLOTS   = DEF_NUM_SLOTS,
    parameter int SLOT_W      = idx_width(NUM_SLOTS),
    parameter int DEAD_CYCLES = DEF_DEAD_CYCLES,
    parameter int FCNT_W      = DEF_FCNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              slot_tick,
    input  logic              frame_tick,
    input  logic              start,
    input  logic              stop,
    input  logic              cfg_we,
    input  logic [SLOT_W-1:0] cfg_addr,
    input  logic [NUM_SW-1:0] cfg_data,
    input  logic              cfg_commit,
    output logic [NUM_SW-1:0] sw_out,
    output logic [SLOT_W-1:0] slot_idx,
    output logic [FCNT_W-1:0] frame_cnt,
    output logic              busy,
    output logic              commit_pending,
    output logic              err_overrun
);

    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);

    seq_state_t        state, state_nxt;
    logic [NUM_SW-1:0] shadow [NUM_SLOTS];
    logic [NUM_SW-1:0] active [NUM_SLOTS];

    logic              running;
    logic              do_copy;
    logic              arm_go;
    logic              drain_end;
    logic              adv;
    logic              ov_set;
    logic [SLOT_W-1:0] slot_nxt;
    logic [NUM_SW-1:0] pat_sel;
    logic              blank_load;
    logic              blank_clear;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start && !stop) state_nxt = ST_ARMED;
            ST_ARMED: if (stop) state_nxt = ST_IDLE;
                      else if (frame_tick) state_nxt = ST_RUN;
            ST_RUN:   if (stop) state_nxt = ST_DRAIN;
            ST_DRAIN: if (frame_tick) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        running   = (state == ST_RUN) || (state == ST_DRAIN);
        arm_go    = (state == ST_ARMED) && !stop && frame_tick;
        drain_end = (state == ST_DRAIN) && frame_tick;
        adv       = running && (frame_tick || slot_tick);
        // While running the table swap waits for the frame boundary.
        do_copy   = commit_pending && (running ? frame_tick : 1'b1);

        slot_nxt = slot_idx;
        ov_set   = 1'b0;
        if (state == ST_ARMED) begin
            slot_nxt = '0;
        end else if (running) begin
            if (frame_tick) begin
                slot_nxt = '0;
                ov_set   = (slot_idx != LAST_SLOT);
            end else if (slot_tick) begin
                if (slot_idx == LAST_SLOT) begin
                    ov_set = 1'b1;
                end else begin
                    slot_nxt = slot_idx + SLOT_W'(1);
                end
            end
        end

        pat_sel     = do_copy ? shadow[slot_nxt] : active[slot_nxt];
        blank_load  = arm_go || (adv && !drain_end);
        blank_clear = (state == ST_IDLE) || drain_end;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= ST_IDLE;
            busy           <= 1'b0;
            slot_idx       <= '0;
            frame_cnt      <= '0;
            commit_pending <= 1'b0;
            err_overrun    <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != ST_IDLE);

            if (cfg_we) begin
                shadow[cfg_addr] <= cfg_data;
            end
            if (do_copy) begin
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    active[i] <= shadow[i];
                end
            end

            if (cfg_commit) begin
                commit_pending <= 1'b1;
            end else if (do_copy) begin
                commit_pending <= 1'b0;
            end

            if (arm_go) begin
                slot_idx    <= '0;
                frame_cnt   <= '0;
                err_overrun <= 1'b0;
            end else if (adv) begin
                slot_idx <= slot_nxt;
                if (frame_tick && !drain_end && (frame_cnt != '1)) begin
                    frame_cnt <= frame_cnt + FCNT_W'(1);
                end
                if (ov_set) begin
                    err_overrun <= 1'b1;
                end
            end
        end
    end

    sw_blanker #(
        .NUM_SW      (NUM_SW),
        .DEAD_CYCLES (DEAD_CYCLES)
    ) u_blanker (
        .clk    (clk),
        .rst    (reset),
        .clear  (blank_clear),
        .load   (blank_load),
        .target (pat_sel),
        .sw_out (sw_out)
    );

endmodule

// File: tb/tb_switch_sequencer.sv
// Directed bench for switch_sequencer: table programming, dead-time blanking,
// frame-boundary commit, overrun detection, drain/stop and reset mid-blank.
module tb_switch_sequencer;

    logic        clk;
    logic        reset;
    logic        slot_tick;
    logic        frame_tick;
    logic        start;
    logic        stop;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [3:0]  cfg_data;
    logic        cfg_commit;
    logic [3:0]  sw_out;
    logic [2:0]  slot_idx;
    logic [15:0] frame_cnt;
    logic        busy;
    logic        commit_pending;
    logic        err_overrun;

    int total = 0;
    int bad   = 0;

    switch_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .slot_tick      (slot_tick),
        .frame_tick     (frame_tick),
        .start          (start),
        .stop           (stop),
        .cfg_we         (cfg_we),
        .cfg_addr       (cfg_addr),
        .cfg_data       (cfg_data),
        .cfg_commit     (cfg_commit),
        .sw_out         (sw_out),
        .slot_idx       (slot_idx),
        .frame_cnt      (frame_cnt),
        .busy           (busy),
        .commit_pending (commit_pending),
        .err_overrun    (err_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish within time limit");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick(input logic f);
        slot_tick  = 1'b1;
        frame_tick = f;
        step();
        slot_tick  = 1'b0;
        frame_tick = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [3:0] d);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        step();
        cfg_we   = 1'b0;
    endtask

    task automatic pulse_commit();
        cfg_commit = 1'b1;
        step();
        cfg_commit = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Called one cycle after a tick that changes the pattern: two blank cycles then p.
    task automatic blank_seq(input string tag, input logic [3:0] p);
        check({tag, "_blank1"}, 32'(sw_out), 0);
        step();
        check({tag, "_blank2"}, 32'(sw_out), 0);
        step();
        check({tag, "_pat"}, 32'(sw_out), 32'(p));
    endtask

    initial begin
        reset = 1'b1;
        slot_tick = 1'b0; frame_tick = 1'b0; start = 1'b0; stop = 1'b0;
        cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; cfg_commit = 1'b0;
        repeat (3) step();
        check("rst_sw", 32'(sw_out), 0);
        check("rst_slot", 32'(slot_idx), 0);
        check("rst_fcnt", 32'(frame_cnt), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_pend", 32'(commit_pending), 0);
        check("rst_err", 32'(err_overrun), 0);
        reset = 1'b0;
        step();

        // Program slot k = k+1 and commit while idle.
        for (int k = 0; k < 8; k++) wr(3'(k), 4'(k + 1));
        pulse_commit();
        check("idle_pend_set", 32'(commit_pending), 1);
        step();
        check("idle_pend_clr", 32'(commit_pending), 0);
        pulse_start();
        check("armed_busy", 32'(busy), 1);
        check("armed_sw", 32'(sw_out), 0);

        tick(1'b1);
        blank_seq("f0_s0", 4'h1);
        check("f0_slot", 32'(slot_idx), 0);
        check("f0_fcnt", 32'(frame_cnt), 0);
        for (int k = 1; k <= 4; k++) begin
            tick(1'b0);
            blank_seq($sformatf("f0_s%0d", k), 4'(k + 1));
            check($sformatf("f0_slot%0d", k), 32'(slot_idx), k);
        end

        // Mid-frame reprogram: the running frame must not change.
        wr(3'd0, 4'hF);
        wr(3'd2, 4'hA);
        wr(3'd3, 4'hA);
        wr(3'd6, 4'hC);
        pulse_commit();
        check("run_pend_set", 32'(commit_pending), 1);
        check("run_sw_hold", 32'(sw_out), 5);
        for (int k = 5; k <= 7; k++) begin
            tick(1'b0);
            blank_seq($sformatf("f0_old_s%0d", k), 4'(k + 1));
        end
        check("run_pend_wait", 32'(commit_pending), 1);

        tick(1'b1);
        blank_seq("f1_s0", 4'hF);
        check("f1_pend_clr", 32'(commit_pending), 0);
        check("f1_fcnt", 32'(frame_cnt), 1);
        check("f1_err", 32'(err_overrun), 0);

        // Equal consecutive patterns hold with no dead time.
        tick(1'b0);
        blank_seq("f1_s1", 4'h2);
        tick(1'b0);
        blank_seq("f1_s2", 4'hA);
        tick(1'b0);
        check("eq_c1", 32'(sw_out), 32'hA);
        step();
        check("eq_c2", 32'(sw_out), 32'hA);
        step();
        check("eq_c3", 32'(sw_out), 32'hA);
        check("eq_slot", 32'(slot_idx), 3);

        // Early frame_tick at slot 5, then too many slot ticks.
        tick(1'b0);
        tick(1'b0);
        check("ov_pre_slot", 32'(slot_idx), 5);
        check("ov_pre_err", 32'(err_overrun), 0);
        tick(1'b1);
        check("ov_err", 32'(err_overrun), 1);
        check("ov_slot", 32'(slot_idx), 0);
        check("ov_fcnt", 32'(frame_cnt), 2);
        repeat (8) tick(1'b0);
        check("hold_slot", 32'(slot_idx), 7);
        step();
        step();
        check("hold_sw", 32'(sw_out), 8);
        check("hold_err", 32'(err_overrun), 1);

        // Stop at slot 3 drains the remainder of the frame.
        tick(1'b1);
        check("f3_fcnt", 32'(frame_cnt), 3);
        step();
        step();
        for (int k = 1; k <= 3; k++) tick(1'b0);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("drain_busy_s3", 32'(busy), 1);
        for (int k = 4; k <= 7; k++) begin
            tick(1'b0);
            check($sformatf("drain_busy_s%0d", k), 32'(busy), 1);
        end
        step();
        step();
        check("drain_sw_s7", 32'(sw_out), 8);
        tick(1'b1);
        check("end_sw", 32'(sw_out), 0);
        check("end_busy", 32'(busy), 0);
        check("end_slot", 32'(slot_idx), 0);
        check("end_err_sticky", 32'(err_overrun), 1);
        step();
        step();
        check("end_sw_stays", 32'(sw_out), 0);

        // start and stop together in IDLE: stop wins.
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        check("ss_busy", 32'(busy), 0);
        tick(1'b1);
        check("ss_busy_ft", 32'(busy), 0);
        check("ss_sw", 32'(sw_out), 0);

        // Re-arm clears err, then reset lands inside a blank window.
        pulse_start();
        tick(1'b1);
        check("rearm_err_clr", 32'(err_overrun), 0);
        check("rearm_fcnt", 32'(frame_cnt), 0);
        step();
        step();
        check("rearm_sw", 32'(sw_out), 32'hF);
        tick(1'b0);
        step();
        step();
        check("rearm_s1", 32'(sw_out), 2);
        tick(1'b1);
        check("pre_rst_err", 32'(err_overrun), 1);
        check("pre_rst_fcnt", 32'(frame_cnt), 1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_sw", 32'(sw_out), 0);
        check("mid_rst_slot", 32'(slot_idx), 0);
        check("mid_rst_fcnt", 32'(frame_cnt), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_pend", 32'(commit_pending), 0);
        check("mid_rst_err", 32'(err_overrun), 0);
        step();
        reset = 1'b0;
        step();

        // Tables were cleared: the restarted run drives all zeros.
        pulse_start();
        tick(1'b1);
        check("post_rst_busy", 32'(busy), 1);
        check("post_rst_slot", 32'(slot_idx), 0);
        check("post_rst_sw1", 32'(sw_out), 0);
        step();
        step();
        check("post_rst_sw3", 32'(sw_out), 0);
        tick(1'b0);
        check("post_rst_slot1", 32'(slot_idx), 1);
        step();
        step();
        check("post_rst_s1_sw", 32'(sw_out), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
